// File: rtl/adder_share_pkg.sv
// adder_share_pkg
// Shared definitions for the shared-adder sequencing controller:
//   - state_t   : controller FSM encoding (IDLE/ADD/HOLD)
//   - N_REQ_DEF : default requester count
//   - W_DEF     : default operand width
//   - clog2()   : ID width helper (never returns less than 1)
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 20;

    // Width needed to index n requesters; a single-bit ID is kept even for
    // n <= 2 so port widths never collapse to zero.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/adder_share_arb.sv
// adder_share_arb
// Combinational grant selection for the shared adder.
//   req_valid : per-requester pending request
//   ptr       : index of the last granted requester (round-robin build only)
//   gnt       : one-hot grant (all zero when nothing is pending)
//   gnt_idx   : binary index of the granted requester
//   gnt_any   : at least one request pending
// Build option ADDER_SHARE_RR_EN: defined -> round-robin starting at ptr+1,
// undefined -> fixed priority with the lowest index winning.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDW   = clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req_valid,
`ifdef ADDER_SHARE_RR_EN
    input  logic [IDW-1:0]   ptr,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
`ifdef ADDER_SHARE_RR_EN
        // Walk N_REQ slots starting just after the last winner; offset N_REQ
        // lands back on ptr itself so a lone repeat requester still wins.
        for (int off = 1; off <= N_REQ; off++) begin
            if (!gnt_any && req_valid[(int'(ptr) + off) % N_REQ]) begin
                gnt[(int'(ptr) + off) % N_REQ] = 1'b1;
                gnt_idx = IDW'((int'(ptr) + off) % N_REQ);
                gnt_any = 1'b1;
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
                gnt_any = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
// Shares one W-bit adder among N_REQ requesters. A pending request is
// accepted in IDLE (one-hot req_ready), its operands and ID are captured,
// the W+1-bit sum is registered in ADD, and HOLD presents it until the
// consumer handshakes. One result per three cycles at best.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid[N_REQ]    : request pending per requester
//   req_in1/req_in2     : operands, requester i in bits [i*W +: W]
//   req_ready[N_REQ]    : one-hot accept strobe (IDLE only)
//   res_valid/res_ready : result handshake
//   res_data[W+1]       : in1+in2 of the granted request, carry in MSB
//   res_id              : requester that produced res_data
// Build option ADDER_SHARE_RR_EN: round-robin grant with a last-winner
// pointer; without it, fixed lowest-index priority and no pointer register.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int W     = W_DEF,
    localparam int IDW   = clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_in1,
    input  logic [N_REQ*W-1:0] req_in2,
    output logic [N_REQ-1:0]   req_ready,
    output logic               res_valid,
    output logic [W:0]         res_data,
    output logic [IDW-1:0]     res_id,
    input  logic               res_ready
);

    typedef struct packed {
        logic [W-1:0]   op1;
        logic [W-1:0]   op2;
        logic [IDW-1:0] id;
    } cap_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             accept;
    logic [W-1:0]     sel_op1, sel_op2;
    cap_t             cap;

`ifdef ADDER_SHARE_RR_EN
    logic [IDW-1:0]   rr_ptr;

    // Reset to N_REQ-1 so the first search starts at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rr_ptr <= IDW'(N_REQ - 1);
        else if (accept) rr_ptr <= gnt_idx;
    end
`endif

    adder_share_arb #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_arb (
        .req_valid (req_valid),
`ifdef ADDER_SHARE_RR_EN
        .ptr       (rr_ptr),
`endif
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_op1 = '0;
        sel_op2 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_op1 = req_in1[i*W +: W];
                sel_op2 = req_in2[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // req_ready is gated by rst_n so it reads zero for the whole reset
    // window, even while requesters hold req_valid high.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rst_n && gnt_any) begin
                    req_ready = gnt;
                    accept    = 1'b1;
                    state_d   = ADD;
                end
            end
            ADD:     state_d = HOLD;
            HOLD:    if (res_valid && res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap       <= '0;
            res_data  <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            if (accept) cap <= '{op1: sel_op1, op2: sel_op2, id: gnt_idx};
            if (state_q == ADD) begin
                res_data  <= {1'b0, cap.op1} + {1'b0, cap.op2};
                res_id    <= cap.id;
                res_valid <= 1'b1;
            end else if (state_q == HOLD && res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;
    import adder_share_pkg::*;

    localparam int N   = 4;
    localparam int W   = 20;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_in1, req_in2;
    logic [N-1:0]     req_ready;
    logic             res_valid;
    logic [W:0]       res_data;
    logic [IDW-1:0]   res_id;
    logic             res_ready;

    int total = 0;
    int bad   = 0;

    // reference model state: 0=idle 1=add 2=hold
    int         m_state;
    int         m_ptr;
    int         cycn = 0;
    logic [W:0] exp_data[$];
    int         exp_id[$];
    int         got_id[$];
    int         got_cyc[$];

    adder_share_ctrl #(.N_REQ(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_grant(input logic [N-1:0] v);
`ifdef ADDER_SHARE_RR_EN
        for (int k = 1; k <= N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
`else
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_ptr   = N - 1;
        exp_data.delete();
        exp_id.delete();
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_data"},  32'(res_data),  32'd0);
        chk({tag, "_res_id"},    32'(res_id),    32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    // Checks outputs against the scoreboard model, then advances the model.
    task automatic cyc();
        int g;
        #1;
        g = (m_state == 0) ? m_grant(req_valid) : -1;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("res_valid", 32'(res_valid), (m_state == 2) ? 32'd1 : 32'd0);
        if (m_state == 2) begin
            if (exp_data.size() > 0) begin
                chk("res_data", 32'(res_data), 32'(exp_data[0]));
                chk("res_id",   32'(res_id),   32'(exp_id[0]));
            end else begin
                total++;
                bad++;
                $error("FAIL scoreboard_empty observed=%0h expected=queued_result", res_data);
            end
        end
        case (m_state)
            0: if (g >= 0) begin
                exp_data.push_back({1'b0, req_in1[g*W +: W]} + {1'b0, req_in2[g*W +: W]});
                exp_id.push_back(g);
                m_ptr   = g;
                m_state = 1;
            end
            1: m_state = 2;
            default: if (res_ready) begin
                got_id.push_back(int'(res_id));
                got_cyc.push_back(cycn);
                if (exp_data.size() > 0) begin
                    void'(exp_data.pop_front());
                    void'(exp_id.pop_front());
                end
                m_state = 0;
            end
        endcase
        @(negedge clk);
        cycn++;
    endtask

    initial begin
        int exp_seq[5];

        rst_n     = 1'b0;
        req_valid = '0;
        req_in1   = '0;
        req_in2   = '0;
        res_ready = 1'b1;
        model_reset();

        // reset state, with requests pending to show req_ready stays low
        #2;
        req_valid = '1;
        #1;
        rst_chk("reset");
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // single request, carry out of the top bit
        req_valid = 4'b0001;
        req_in1[0*W +: W] = 20'hFFFFF;
        req_in2[0*W +: W] = 20'h00001;
        cyc();
        req_valid = '0;
        cyc();
        #1;
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data",  32'(res_data),  32'h100000);
        chk("single_id",    32'(res_id),    32'd0);
        cyc();

        // operands change while the add is in flight
        req_valid = 4'b0010;
        req_in1[1*W +: W] = 20'h11111;
        req_in2[1*W +: W] = 20'h22222;
        cyc();
        req_in1   = {N{20'hABCDE}};
        req_in2   = {N{20'h0F0F0}};
        req_valid = '0;
        cyc();
        #1;
        chk("inflight_data", 32'(res_data), 32'h033333);
        chk("inflight_id",   32'(res_id),   32'd1);
        cyc();

        // backpressure: consumer stalls for 10 cycles, others keep requesting
        res_ready = 1'b0;
        req_valid = 4'b0100;
        req_in1[2*W +: W] = 20'h12345;
        req_in2[2*W +: W] = 20'h54321;
        cyc();
        req_valid = '1;
        cyc();
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp_data",  32'(res_data),  32'h066666);
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            cyc();
        end
        res_ready = 1'b1;
        cyc();
        #1;
        chk("bp_cleared", 32'(res_valid), 32'd0);
        cyc();
        cyc();

        // reset while a result is held
        #2;
        rst_n = 1'b0;
        #1;
        rst_chk("rst_hold");
        model_reset();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_in1[i*W +: W] = W'(32'h11111 * (i + 1) + 5);
            req_in2[i*W +: W] = W'(32'hF0000 - i);
        end
        req_valid = '1;
        rst_n = 1'b1;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'd1);
        got_id.delete();
        got_cyc.delete();

        // all requesters continuously pending, consumer always ready
        for (int k = 0; k < 15; k++) cyc();
`ifdef ADDER_SHARE_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif
        chk("seq_count", 32'(got_id.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_id.size(); i++)
            chk("seq_id", 32'(got_id[i]), 32'(exp_seq[i]));
        for (int i = 1; i < got_cyc.size(); i++)
            chk("seq_spacing", 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);

        req_valid = '0;
        for (int k = 0; k < 4; k++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
